mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control state machine for the multicycle variant of the 32-bit MIPS core. It sequences the single shared ALU, memory port, instruction register and register file across Fetch/Decode/Execute/Writeback states. ALUControl is derived from a per-state ALUOp plus the instruction Funct field. A MemReady handshake lets the block stall on a slow unified memory.

## Interface
Parameters:
- none; opcode and state encodings are fixed constants (see Structure).

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- Opcode  in  6  Instr[31:26] from instruction register
- Funct  in  6  Instr[5:0]
- Zero  in  1  ALU zero flag, valid in BRANCH
- MemReady  in  1  memory completes current access this cycle
- IorD  out  1  0: address = PC, 1: address = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- RegDst  out  1  0: rt, 1: rd
- MemtoReg  out  1  0: ALUOut, 1: Data register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0: PC, 1: register A
- ALUSrcB  out  2  00: B, 01: const 4, 10: SignImm, 11: SignImm<<2
- PCSrc  out  2  00: ALUResult, 01: ALUOut, 10: jump target
- PCEn  out  1  PCWrite | (Branch & Zero)
- ALUControl  out  3  010 add, 100 sub, 110 slt, 101 mul
- Illegal  out  1  one-cycle pulse on unsupported opcode
- State  out  4  current state, debug only

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and return to FETCH.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=MemReady. Stay in FETCH while !MemReady; go to DECODE when MemReady.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed). Next state by opcode:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH, with Illegal=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
- MEMRD: IorD=1. Wait for MemReady, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1 held until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.
- ALU decode:
  - ALUOp 00 → 010; ALUOp 01 → 100.
  - ALUOp 10: Funct 100000 → 010, 100010 → 100, 101010 → 110, 011100 → 101, other → 010.
  - ALUOp 11 → 010.
- Every output not listed for a state is 0 in that state (ALUControl is always the decoded value).

## Timing
- Outputs are combinational from State plus MemReady/Zero/Opcode/Funct; no output register, zero latency.
- Reset: State=FETCH on the first edge with RST=1. RST overrides every transition, including mid-instruction.
- While RST is high, outputs show FETCH values: IorD=0, ALUSrcB=01, ALUControl=010. IRWrite and PCEn equal MemReady; system integration gates memory during reset.
- Cycle counts per instruction with MemReady constantly 1:
  - beq and j: 3 cycles
  - R, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. MemWrite stays asserted through the stall.
- Zero is sampled only in BRANCH; PCEn=Zero there.
- MemReady is ignored in all non-memory states.

## Structure
- Shared package mips_pkg holds:
  - opcode constants
  - state encoding (4-bit enum)
  - ALUOp and ALUControl codes, shared with the datapath and the single-cycle decoder.
- One sub-module: ALU_Decoder (ALUOp, Funct → ALUControl). It is instantiated unchanged. The FSM produces ALUOp only.

## Test plan
- R-type add (Opcode 000000, Funct 100000), MemReady=1 → states 0,1,6,7,0; ALUControl=010 in EXEC; RegWrite=1 and RegDst=1 only in ALUWB.
- lw with MemReady low 2 cycles in FETCH and 1 in MEMRD → 8 cycles total; IRWrite=1 exactly once; MemtoReg=RegWrite=1 in MEMWB.
- beq:
  - Zero=1 in BRANCH → PCEn=1, PCSrc=01, ALUControl=100.
  - Zero=0 → PCEn=0.
  - Both cases return to FETCH after 3 cycles.
- sw with MemReady=0 for 3 cycles in MEMWR → MemWrite high 4 consecutive cycles, then FETCH; RegWrite is never asserted.
- Illegal opcode 111111 → Illegal pulses in DECODE for exactly one cycle, next state FETCH; no RegWrite/MemWrite.
- RST asserted in ADDIEX → State=0 on the next edge; no ADDIWB RegWrite occurs. RST held 3 cycles → State stays 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, FSM states, ALUOp and ALUControl.
// Imported by the control FSM, the ALU decoder, the datapath and the single-cycle decoder.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_FN  = 2'b10,
    ALUOP_RSV = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master: controller (drives strobes/selects); slave: datapath (drives instr fields, flags).
interface mips_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, Illegal, State
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// ALU decoder: maps ALUOp and the R-type Funct field to ALUControl.
// Ports: ALUOp in, Funct in, ALUControl out. Shared with the single-cycle core.
module ALU_Decoder
  import mips_pkg::*;
(
  input  aluop_t     ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FN: begin
        case (Funct)
          FN_SUB:  ALUControl = ALU_SUB;
          FN_SLT:  ALUControl = ALU_SLT;
          FN_MUL:  ALUControl = ALU_MUL;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with MemReady stall handshake.
// Ports: CLK, RST (sync, active-high), bus (mips_ctrl_if.master).
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  mips_ctrl_if.master bus
);

  state_t state;
  state_t next;
  state_t cur;
  aluop_t alu_op;
  logic   pc_write;
  logic   branch;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= next;
  end

  // Reset makes the outputs look like FETCH even mid-instruction,
  // so a half-finished write-back never fires.
  assign cur = RST ? S_FETCH : state;

  always_comb begin
    next         = S_FETCH;
    alu_op       = ALUOP_ADD;
    pc_write     = 1'b0;
    branch       = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.PCSrc    = 2'b00;
    bus.Illegal  = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        pc_write    = bus.MemReady;
        next        = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:         next = S_EXEC;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JUMP;
          default: begin
            next        = S_FETCH;
            bus.Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        next = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.IorD = 1'b1;
        next = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        next = bus.MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_FN;
        next        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = ALUOP_SUB;
        bus.PCSrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        next        = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
      end
      S_JUMP: begin
        bus.PCSrc = 2'b10;
        pc_write  = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  assign bus.PCEn  = pc_write | (branch & bus.Zero);
  assign bus.State = state;

  ALU_Decoder u_alu_dec (
    .ALUOp      (alu_op),
    .Funct      (bus.Funct),
    .ALUControl (bus.ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an instruction-level model.
// Builds each instruction's expected state trace, then checks every cycle.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] aluctl;
    logic       illegal;
  } out_t;

  typedef struct {
    int st;
    bit mr;
  } step_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_fail = 0;

  mips_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  out_t obs;
  always_comb obs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
                     bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                     bus.PCSrc, bus.PCEn, bus.ALUControl, bus.Illegal};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000,
                      6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] funct_ctl(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b100;
      6'b101010: return 3'b110;
      6'b011100: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st.
  function automatic out_t model(int st, bit mr, bit z,
                                 logic [5:0] op, logic [5:0] fn);
    out_t o;
    o = '0;
    o.aluctl = 3'b010;
    case (st)
      0: begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
      1: begin o.alusrcb = 2'b11; o.illegal = !legal(op); end
      2: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3: o.iord = 1;
      4: begin o.memtoreg = 1; o.regwrite = 1; end
      5: begin o.iord = 1; o.memwrite = 1; end
      6: begin o.alusrca = 1; o.aluctl = funct_ctl(fn); end
      7: begin o.regdst = 1; o.regwrite = 1; end
      8: begin o.alusrca = 1; o.pcsrc = 2'b01; o.pcen = z; o.aluctl = 3'b100; end
      9: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1;
      11: begin o.pcsrc = 2'b10; o.pcen = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Run one instruction; fs/ms are stall cycles in FETCH and MEMRD/MEMWR.
  // Returns DUT-observed pulse counts.
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input int fs, input int ms, input bit z,
                     output int irw, output int mw,
                     output int rw, output int ill);
    step_t q[$];
    bit zz;
    irw = 0; mw = 0; rw = 0; ill = 0;
    for (int i = 0; i < fs; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, rbit()});
    case (op)
      6'b100011: begin
        q.push_back('{2, rbit()});
        for (int i = 0; i < ms; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, rbit()});
      end
      6'b101011: begin
        q.push_back('{2, rbit()});
        for (int i = 0; i < ms; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      6'b000000: begin q.push_back('{6, rbit()}); q.push_back('{7, rbit()}); end
      6'b000100: q.push_back('{8, rbit()});
      6'b001000: begin q.push_back('{9, rbit()}); q.push_back('{10, rbit()}); end
      6'b000010: q.push_back('{11, rbit()});
      default: ;
    endcase
    foreach (q[i]) begin
      zz = (q[i].st == 8) ? z : rbit();
      bus.Opcode   = op;
      bus.Funct    = fn;
      bus.MemReady = q[i].mr;
      bus.Zero     = zz;
      #1;
      chk($sformatf("state[%0d] op=%b", i, op), 32'(bus.State), 32'(q[i].st));
      chk($sformatf("outs[%0d] st=%0d", i, q[i].st), 32'(obs),
          32'(model(q[i].st, q[i].mr, zz, op, fn)));
      irw += int'(bus.IRWrite);
      mw  += int'(bus.MemWrite);
      rw  += int'(bus.RegWrite);
      ill += int'(bus.Illegal);
      @(posedge CLK);
      #1;
    end
    bus.MemReady = 1'b1;
    #1;
    chk("back_to_fetch", 32'(bus.State), 32'd0);
  endtask

  localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                     6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] FNS [4] = '{6'b100000, 6'b100010,
                                     6'b101010, 6'b011100};

  initial begin
    int irw, mw, rw, ill;
    logic [5:0] op, fn;
    RST = 1'b1;
    bus.Opcode = 6'b0; bus.Funct = 6'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b1;
    @(posedge CLK); #1;
    chk("reset_state", 32'(bus.State), 32'd0);
    chk("reset_outs", 32'(obs), 32'(model(0, 1'b1, 1'b0, 6'b0, 6'b0)));
    bus.MemReady = 1'b0; #1;
    chk("reset_irwrite_mr0", 32'(bus.IRWrite), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    run(6'b000000, 6'b100000, 0, 0, 1'b0, irw, mw, rw, ill);
    chk("radd_regwrite", 32'(rw), 32'd1);
    run(6'b100011, 6'b000000, 2, 1, 1'b0, irw, mw, rw, ill);
    chk("lw_irwrite_once", 32'(irw), 32'd1);
    chk("lw_regwrite", 32'(rw), 32'd1);
    run(6'b000100, 6'b000000, 0, 0, 1'b1, irw, mw, rw, ill);
    run(6'b000100, 6'b000000, 0, 0, 1'b0, irw, mw, rw, ill);
    run(6'b101011, 6'b000000, 0, 3, 1'b0, irw, mw, rw, ill);
    chk("sw_memwrite_cycles", 32'(mw), 32'd4);
    chk("sw_no_regwrite", 32'(rw), 32'd0);
    run(6'b111111, 6'b000000, 0, 0, 1'b0, irw, mw, rw, ill);
    chk("illegal_pulse", 32'(ill), 32'd1);
    chk("illegal_no_write", 32'(rw + mw), 32'd0);
    run(6'b000010, 6'b000000, 1, 0, 1'b0, irw, mw, rw, ill);

    // Reset in ADDIEX aborts the write-back.
    bus.Opcode = 6'b001000; bus.MemReady = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("addiex_reached", 32'(bus.State), 32'd9);
    RST = 1'b1; #1;
    chk("rst_outs_fetch", 32'(obs), 32'(model(0, 1'b1, 1'b0, 6'b001000, 6'b0)));
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("rst_hold[%0d]", i), 32'(bus.State), 32'd0);
      chk($sformatf("rst_no_regwrite[%0d]", i), 32'(bus.RegWrite), 32'd0);
    end
    RST = 1'b0;

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 3)];
      run(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rbit(),
          irw, mw, rw, ill);
      chk("rand_irwrite_once", 32'(irw), 32'd1);
      chk("rand_illegal", 32'(ill), 32'(!legal(op)));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
